// File: rtl/friscv_pkg.sv
// Shared integer-core definitions: register file geometry and writeback grant encoding.
package friscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int NREG   = 1 << REG_AW;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard with RAW/WAW hazard detection for decode.
// WB_BYPASS_EN releases hazards on the register being written this cycle and forwards rf_wdata.
module rf_scoreboard
  import friscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic              rf_we,
  input  logic [REG_AW-1:0] rf_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              dec_stall,
  output logic              byp_a_en,
  output logic              byp_b_en
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_hit_rs1;
  logic            w_hit_rs2;
  logic            w_hit_rd;

  // Set is applied after clear so a same-edge issue to a retiring register keeps it busy.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (iss_valid && (iss_rd != '0)) w_set[iss_rd] = 1'b1;
    if (rf_we) w_clr[rf_rd] = 1'b1;
    w_busy_nxt    = (r_busy & ~w_clr) | w_set;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

`ifdef WB_BYPASS_EN
  logic w_fwd_rs1;
  logic w_fwd_rs2;
  logic w_fwd_rd;

  always_comb begin
    w_fwd_rs1 = rf_we && (rf_rd == dec_rs1);
    w_fwd_rs2 = rf_we && (rf_rd == dec_rs2);
    w_fwd_rd  = rf_we && (rf_rd == dec_rd);
    w_hit_rs1 = r_busy[dec_rs1] && (dec_rs1 != '0) && !w_fwd_rs1;
    w_hit_rs2 = r_busy[dec_rs2] && (dec_rs2 != '0) && !w_fwd_rs2;
    w_hit_rd  = r_busy[dec_rd]  && (dec_rd  != '0) && !w_fwd_rd;
  end

  assign byp_a_en = w_fwd_rs1;
  assign byp_b_en = w_fwd_rs2;
`else
  always_comb begin
    w_hit_rs1 = r_busy[dec_rs1] && (dec_rs1 != '0);
    w_hit_rs2 = r_busy[dec_rs2] && (dec_rs2 != '0);
    w_hit_rd  = r_busy[dec_rd]  && (dec_rd  != '0);
  end

  assign byp_a_en = 1'b0;
  assign byp_b_en = 1'b0;
`endif

  assign dec_stall = w_hit_rs1 | w_hit_rs2 | w_hit_rd;

endmodule

// File: rtl/rf_wb_sched.sv
// Round-robin writeback arbiter (ALU vs LSU) with registered register-file write port.
// Optional forwarding controlled by macro WB_BYPASS_EN (handled in rf_scoreboard).
module rf_wb_sched
  import friscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              dec_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              byp_a_en,
  output logic              byp_b_en
);

  gnt_e              r_last_gnt;
  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_rd;
  logic [XLEN-1:0]   r_rf_wdata;
  logic              w_alu_hs;
  logic              w_lsu_hs;
  logic [REG_AW-1:0] w_wr_rd;
  logic [XLEN-1:0]   w_wr_data;

  // A requester is ready unless the other one is asking and owns the tie.
  assign alu_ready = !lsu_valid || (r_last_gnt == GNT_LSU);
  assign lsu_ready = !alu_valid || (r_last_gnt == GNT_ALU);
  assign w_alu_hs  = alu_valid && alu_ready;
  assign w_lsu_hs  = lsu_valid && lsu_ready;
  assign w_wr_rd   = w_lsu_hs ? lsu_rd   : alu_rd;
  assign w_wr_data = w_lsu_hs ? lsu_data : alu_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_gnt <= GNT_ALU;
      r_rf_we    <= 1'b0;
      r_rf_rd    <= '0;
      r_rf_wdata <= '0;
    end else if (w_alu_hs || w_lsu_hs) begin
      r_last_gnt <= w_lsu_hs ? GNT_LSU : GNT_ALU;
      r_rf_we    <= (w_wr_rd != '0);
      r_rf_rd    <= w_wr_rd;
      r_rf_wdata <= w_wr_data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  assign rf_we    = r_rf_we;
  assign rf_rd    = r_rf_rd;
  assign rf_wdata = r_rf_wdata;

  rf_scoreboard u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rf_we     (r_rf_we),
    .rf_rd     (r_rf_rd),
    .dec_rs1   (dec_rs1),
    .dec_rs2   (dec_rs2),
    .dec_rd    (dec_rd),
    .dec_stall (dec_stall),
    .byp_a_en  (byp_a_en),
    .byp_b_en  (byp_b_en)
  );

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed and randomized bench for rf_wb_sched against a register-level behavioural model.
module tb_rf_wb_sched;
  import friscv_pkg::*;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              alu_valid, lsu_valid, iss_valid;
  logic              alu_ready, lsu_ready;
  logic [REG_AW-1:0] alu_rd, lsu_rd, iss_rd;
  logic [XLEN-1:0]   alu_data, lsu_data;
  logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
  logic              dec_stall, rf_we, byp_a_en, byp_b_en;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  int total = 0;
  int bad   = 0;

  // Model: who won last, what the write port holds, which registers await a write.
  bit                m_last_lsu;
  bit                m_we;
  logic [REG_AW-1:0] m_rd;
  logic [XLEN-1:0]   m_data;
  bit                m_busy [NREG];
  bit                g_alu_hs, g_lsu_hs;

  always #5 clk = ~clk;

  rf_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_stall(dec_stall),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .byp_a_en(byp_a_en), .byp_b_en(byp_b_en)
  );

  function automatic bit hazard(logic [REG_AW-1:0] r);
    return (r != 0) && m_busy[r] && !(BYP && m_we && (m_rd == r));
  endfunction

  function automatic bit expStall();
    return hazard(dec_rs1) || hazard(dec_rs2) || hazard(dec_rd);
  endfunction

  function automatic bit aluWins();
    return alu_valid && (!lsu_valid || m_last_lsu);
  endfunction

  function automatic bit lsuWins();
    return lsu_valid && !aluWins();
  endfunction

  function automatic bit fwd(logic [REG_AW-1:0] r);
    return BYP && m_we && (m_rd == r);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                               input bit lv, input logic [REG_AW-1:0] lrd, input logic [XLEN-1:0] ld,
                               input bit iv, input logic [REG_AW-1:0] ird,
                               input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                               input logic [REG_AW-1:0] drd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    iss_valid = iv; iss_rd = ird;
    dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = drd;
  endtask

  // Compare every output against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    checkOutput("alu_ready", 32'(alu_ready), 32'(!(lsu_valid && !m_last_lsu)));
    checkOutput("lsu_ready", 32'(lsu_ready), 32'(!(alu_valid && m_last_lsu)));
    checkOutput("rf_we", 32'(rf_we), 32'(m_we));
    checkOutput("rf_rd", 32'(rf_rd), 32'(m_rd));
    checkOutput("rf_wdata", rf_wdata, m_data);
    checkOutput("dec_stall", 32'(dec_stall), 32'(expStall()));
    checkOutput("byp_a_en", 32'(byp_a_en), 32'(fwd(dec_rs1)));
    checkOutput("byp_b_en", 32'(byp_b_en), 32'(fwd(dec_rs2)));
    checkOutput("protocol_iss_while_stall", 32'(iss_valid && dec_stall), 32'(0));
  endtask

  // Advance the model across the next rising edge, then step past it.
  task automatic advance();
    g_alu_hs = aluWins();
    g_lsu_hs = lsuWins();
    if (!rst_n) begin
      m_last_lsu = 1'b0; m_we = 1'b0; m_rd = '0; m_data = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      g_alu_hs = 1'b0; g_lsu_hs = 1'b0;
    end else begin
      if (m_we) m_busy[m_rd] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      if (g_alu_hs || g_lsu_hs) begin
        m_last_lsu = g_lsu_hs;
        m_rd       = g_lsu_hs ? lsu_rd : alu_rd;
        m_data     = g_lsu_hs ? lsu_data : alu_data;
        m_we       = (m_rd != 0);
      end else begin
        m_we = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    advance();

    $display("[TB] reset release");
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    sample();
    checkOutput("reset_rf_we", 32'(rf_we), 0);
    checkOutput("reset_stall_rs1_5", 32'(dec_stall), 0);
    checkOutput("reset_alu_ready", 32'(alu_ready), 1);
    checkOutput("reset_lsu_ready", 32'(lsu_ready), 1);
    advance();

    $display("[TB] tie after reset");
    applyStimulus(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0, 0);
    sample();
    checkOutput("tie_alu_ready_low", 32'(alu_ready), 0);
    checkOutput("tie_lsu_ready_high", 32'(lsu_ready), 1);
    advance();
    applyStimulus(1, 3, 32'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("tie_first_we", 32'(rf_we), 1);
    checkOutput("tie_first_rd", 32'(rf_rd), 4);
    checkOutput("tie_first_data", rf_wdata, 32'h22);
    advance();

    $display("[TB] write to x0");
    applyStimulus(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("tie_second_rd", 32'(rf_rd), 3);
    checkOutput("tie_second_data", rf_wdata, 32'h11);
    checkOutput("x0_alu_ready", 32'(alu_ready), 1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    checkOutput("x0_no_we", 32'(rf_we), 0);
    advance();

    $display("[TB] RAW hazard on x7");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    sample(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    sample();
    checkOutput("raw_stall_set", 32'(dec_stall), 1);
    advance();
    applyStimulus(0, 0, 0, 1, 7, 32'h77, 0, 0, 0, 7, 0);
    sample(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    sample();
    checkOutput("raw_we_cycle", 32'(rf_we), 1);
    checkOutput("raw_stall_in_we_cycle", 32'(dec_stall), BYP ? 0 : 1);
    checkOutput("raw_byp_b", 32'(byp_b_en), BYP ? 1 : 0);
    advance();
    sample();
    checkOutput("raw_stall_cleared", 32'(dec_stall), 0);
    advance();

    $display("[TB] same-edge set and clear on x9");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    sample(); advance();
    applyStimulus(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    sample();
    checkOutput("same_edge_we_rd", 32'(rf_rd), 9);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);
    sample();
    checkOutput("same_edge_busy_kept", 32'(dec_stall), 1);
    advance();
    applyStimulus(0, 0, 0, 1, 9, 32'h9A, 0, 0, 9, 0, 0);
    sample(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); advance();
    sample(); advance();

    $display("[TB] reset during write to x12");
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0);
    sample(); advance();
    applyStimulus(1, 12, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0);
    sample(); advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12);
    sample();
    checkOutput("midrst_we_before", 32'(rf_we), 1);
    checkOutput("midrst_stall_before", 32'(dec_stall), BYP ? 0 : 1);
    rst_n = 1'b0;
    advance();
    rst_n = 1'b1;
    sample();
    checkOutput("midrst_we_after", 32'(rf_we), 0);
    checkOutput("midrst_stall_after", 32'(dec_stall), 0);
    advance();

    $display("[TB] randomized traffic");
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      if (!alu_valid && ($urandom_range(0, 2) != 0)) begin
        alu_valid = 1'b1;
        alu_rd    = REG_AW'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      if (!lsu_valid && ($urandom_range(0, 2) != 0)) begin
        lsu_valid = 1'b1;
        lsu_rd    = REG_AW'($urandom_range(0, 15));
        lsu_data  = $urandom;
      end
      dec_rs1   = REG_AW'($urandom_range(0, 15));
      dec_rs2   = REG_AW'($urandom_range(0, 15));
      dec_rd    = REG_AW'($urandom_range(0, 15));
      iss_valid = 1'b0;
      iss_rd    = dec_rd;
      if (!expStall() && ($urandom_range(0, 1) != 0)) iss_valid = 1'b1;
      sample();
      advance();
      if (g_alu_hs) alu_valid = 1'b0;
      if (g_lsu_hs) lsu_valid = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Write-port scheduler and register scoreboard for the integer register file. Shares the register file's single write port between two writeback requesters, the ALU and the load/store unit (LSU), using round-robin arbitration with a registered write port. Tracks destination registers with writes still outstanding, and drives the decode-stage stall so that decode never reads a stale operand and never issues a second write to a pending register.

## Interface
- XLEN, 32: data width of the register file.
- REG_AW, 5: register address width (2^REG_AW registers; x0 hard-wired zero).
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid / alu_ready  in / out  1  ALU writeback handshake.
- alu_rd  in  REG_AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid / lsu_ready  in / out  1  LSU writeback handshake.
- lsu_rd  in  REG_AW  LSU destination register.
- lsu_data  in  XLEN  load data.
- iss_valid  in  1  decode issues an instruction that writes iss_rd this cycle.
- iss_rd  in  REG_AW  destination of the issued instruction.
- dec_rs1, dec_rs2, dec_rd  in  REG_AW  source and destination fields of the instruction in decode.
- dec_stall  out  1  hazard; decode must hold and must not assert iss_valid.
- rf_we  out  1  register file write enable.
- rf_rd  out  REG_AW  register file write address.
- rf_wdata  out  XLEN  register file write data.
- byp_a_en, byp_b_en  out  1  substitute rf_wdata for operand A/B (macro-dependent, see Configuration).

## Operation
- **Arbitration:**
  - Only ALU valid: ALU granted. Only LSU valid: LSU granted.
  - Both valid: grant goes to the requester not recorded in last_gnt.
  - last_gnt updates only on a completed handshake.
  - The ready outputs are combinational from the valids and last_gnt; a requester holds valid and payload until ready.
- **Write port:** on a handshake, rd and data are registered onto rf_rd/rf_wdata. rf_we is set when rd != 0. A handshake to x0 completes but produces rf_we=0.
- **Scoreboard:** busy vector of 2^REG_AW bits; bit 0 is always 0.
  - Set: iss_valid and iss_rd != 0 sets busy[iss_rd].
  - Clear: rf_we clears busy[rf_rd].
  - Same register set and cleared at the same edge: set wins.
- **Stall:** dec_stall = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd], each term masked when its register is x0. Checking dec_rd (WAW) guarantees at most one outstanding write per register.
- iss_valid while dec_stall=1 is a protocol violation; the bench asserts against it.
- **Reset (synchronous, takes effect at the edge):**
  - rf_we=0, rf_rd=0, rf_wdata=0, busy=0, last_gnt=ALU (so LSU wins the first tie), byp_a_en=byp_b_en=0.
  - Reset mid-transaction discards any in-flight write; requesters must also be reset.

## Timing
- Handshake at edge N drives rf_we/rf_rd/rf_wdata during cycle N+1. The register file writes, and busy clears, at edge N+1.
- Issue at edge N: dec_stall reflects the new busy bit from cycle N+1.
- Minimum write-port occupancy is one cycle per write; with both requesters valid continuously, grants alternate LSU, ALU, LSU, ...
- dec_stall and the ready outputs are combinational from registered state and current inputs. There is no combinational path from valid to dec_stall.

## Configuration
- Macro: WB_BYPASS_EN.
- **Defined:**
  - During a cycle with rf_we=1, a source register equal to rf_rd (nonzero) is not a stall term.
  - byp_a_en = rf_we & (rf_rd == dec_rs1); byp_b_en likewise for dec_rs2. Decode takes rf_wdata for that operand.
  - The dec_rd (WAW) term is also released in that cycle.
- **Undefined:**
  - byp_a_en and byp_b_en are tied to 0.
  - busy stays asserted through the write cycle, so decode stalls one additional cycle until the register file holds the value.

## Structure
- Shared package friscv_pkg holds XLEN, REG_AW and the grant encoding constants GNT_ALU and GNT_LSU used for last_gnt.
- One sub-module, rf_scoreboard, contains the busy vector, set/clear logic and the hazard/bypass comparison. The top level holds the arbiter and the write-port registers.

## Test plan
- **Reset:** reset held, then released with no valids → rf_we=0, dec_stall=0 for dec_rs1=5; all ready outputs high.
- **Tie:** alu_valid (rd=3, data=0x11) and lsu_valid (rd=4, data=0x22) held together for two cycles after reset:
  - First write: rf_rd=4, data 0x22.
  - Second write: rf_rd=3, data 0x11.
  - alu_ready is low during the first handshake cycle.
- **x0 write:** alu_valid with rd=0, data 0xFFFF_FFFF → alu_ready=1 and rf_we stays 0 the next cycle.
- **RAW hazard:** issue iss_rd=7; next cycle dec_rs2=7 → dec_stall=1. LSU then writes rd=7.
  - With WB_BYPASS_EN: stall drops in the rf_we cycle and byp_b_en=1.
  - Without WB_BYPASS_EN: stall drops one cycle later.
- **Same-edge set and clear:** issue iss_rd=9 at the same edge that rf_we clears busy[9] → busy[9]=1 afterwards, and dec_stall=1 for dec_rs1=9.
- **Reset mid-write:** rst_n low while rf_we=1 and busy[12]=1 → after the edge, rf_we=0 and dec_stall=0 for dec_rd=12.
